// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the random-number generator and its sequence checker.
`default_nettype none

package lfsr_checker_pkg;

    localparam int                   RND_NUM_W = 8;
    localparam logic [RND_NUM_W-1:0] RND_SEED  = 8'h01;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: fills, hunts for lock, then counts bit errors.
`default_nettype none

module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter logic [RND_NUM_W-1:0] TAPS       = RND_NUM_W'(5) << (RND_NUM_W - 3),
    parameter int                   LOCK_CNT   = 16,
    parameter int                   UNLOCK_ERR = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        bit_i,
    input  logic        err_clr_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o
);

    localparam int FILL_W  = $clog2(RND_NUM_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W   = $clog2(UNLOCK_ERR + 1);

    chk_state_t           state, state_nxt;
    logic [RND_NUM_W-1:0] sr;
    logic [FILL_W-1:0]    fill_cnt, fill_nxt;
    logic [MATCH_W-1:0]   match_cnt, match_nxt;
    logic [RUN_W-1:0]     err_run, run_nxt;
    logic [15:0]          cnt_nxt;
    logic                 pred;
    logic                 mismatch;
    logic                 counted;

    // An all-zero register can never predict a live sequence, so it always mismatches.
    assign pred     = ^(sr & TAPS);
    assign mismatch = (sr == '0) || (pred != bit_i);

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        run_nxt   = err_run;
        counted   = 1'b0;
        if (valid_i) begin
            case (state)
                ST_FILL: begin
                    if (fill_cnt == FILL_W'(RND_NUM_W - 1)) begin
                        state_nxt = ST_HUNT;
                        fill_nxt  = '0;
                        match_nxt = '0;
                    end else begin
                        fill_nxt = fill_cnt + 1'b1;
                    end
                end
                ST_HUNT: begin
                    if (mismatch) begin
                        match_nxt = '0;
                    end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                        state_nxt = ST_LOCKED;
                        match_nxt = '0;
                        run_nxt   = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (mismatch) begin
                        counted = 1'b1;
                        if (err_run == RUN_W'(UNLOCK_ERR - 1)) begin
                            state_nxt = ST_FILL;
                            fill_nxt  = '0;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = err_run + 1'b1;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                    fill_nxt  = '0;
                end
            endcase
        end

        // A clear coinciding with a counted error keeps that one error.
        if (err_clr_i) begin
            cnt_nxt = counted ? 16'd1 : 16'd0;
        end else if (counted && (err_cnt_o != 16'hFFFF)) begin
            cnt_nxt = err_cnt_o + 16'd1;
        end else begin
            cnt_nxt = err_cnt_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_FILL;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            err_run   <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= 16'd0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            err_run   <= run_nxt;
            locked_o  <= (state_nxt == ST_LOCKED);
            err_o     <= counted;
            err_cnt_o <= cnt_nxt;
            if (valid_i) begin
                sr <= {sr[RND_NUM_W-2:0], bit_i};
            end
        end
    end

endmodule

`default_nettype wire
